mmio_io_controller: RTL

MMIO_IO_CONTROLLER -- requirements
Module: mmio_io_controller

---
 rtl/mmio_pkg.sv | 25 ++
 rtl/mmio_addr_decoder.sv | 27 ++
 rtl/mmio_io_controller.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// ============================================================================
// mmio_pkg : shared constants, FSM encoding and UART status bit layout
// Revision : 1.0
// ============================================================================
`default_nettype none

package mmio_pkg;

   localparam logic [31:0] C_GPIO_ADDR      = 32'h1001_0024;
   localparam logic [31:0] C_UART_TX_ADDR   = 32'h1001_0020;
   localparam logic [31:0] C_UART_STAT_ADDR = 32'h1001_0028;

   localparam int C_STAT_BUSY_BIT = 0;
   localparam int C_STAT_ERR_BIT  = 1;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_UART_WAIT  = 2'd1,
      ST_UART_START = 2'd2,
      ST_READ_RESP  = 2'd3
   } state_e;

endpackage : mmio_pkg

`default_nettype wire

// File: rtl/mmio_addr_decoder.sv
// ============================================================================
// mmio_addr_decoder : exact-match decode of the CPU address into one-hot hits
// Revision : 1.0
// ============================================================================
`default_nettype none

module mmio_addr_decoder
   import mmio_pkg::*;
#(
   parameter int                     WORD_LENGTH    = 32,
   parameter logic [WORD_LENGTH-1:0] GPIO_ADDR      = C_GPIO_ADDR,
   parameter logic [WORD_LENGTH-1:0] UART_TX_ADDR   = C_UART_TX_ADDR,
   parameter logic [WORD_LENGTH-1:0] UART_STAT_ADDR = C_UART_STAT_ADDR
) (
   input  logic [WORD_LENGTH-1:0] addr_i,
   output logic                   hit_gpio_o,
   output logic                   hit_uart_tx_o,
   output logic                   hit_uart_stat_o
);

   assign hit_gpio_o      = (addr_i == GPIO_ADDR);
   assign hit_uart_tx_o   = (addr_i == UART_TX_ADDR);
   assign hit_uart_stat_o = (addr_i == UART_STAT_ADDR);

endmodule : mmio_addr_decoder

`default_nettype wire

// File: rtl/mmio_io_controller.sv
// ============================================================================
// mmio_io_controller : MMIO bridge for a GPIO register and a UART transmitter.
// Optional UART wait timeout enabled by defining MMIO_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mmio_io_controller
   import mmio_pkg::*;
#(
   parameter int                     WORD_LENGTH    = 32,
   parameter logic [WORD_LENGTH-1:0] GPIO_ADDR      = C_GPIO_ADDR,
   parameter logic [WORD_LENGTH-1:0] UART_TX_ADDR   = C_UART_TX_ADDR,
   parameter logic [WORD_LENGTH-1:0] UART_STAT_ADDR = C_UART_STAT_ADDR,
   parameter int                     TIMEOUT_CYCLES = 1023
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   MemWrite,
   input  logic                   MemRead,
   input  logic [WORD_LENGTH-1:0] Address,
   input  logic [WORD_LENGTH-1:0] WriteData,
   output logic [WORD_LENGTH-1:0] ReadData,
   output logic                   Stall,
   output logic [WORD_LENGTH-1:0] GpioOut,
   output logic [7:0]             UartTxData,
   output logic                   UartTxStart,
   input  logic                   UartBusy,
   output logic                   IoError
);

   state_e                   state_q, state_d;
   logic [WORD_LENGTH-1:0]   gpio_q, gpio_d;
   logic [WORD_LENGTH-1:0]   rdata_q, rdata_d;
   logic [7:0]               txdata_q, txdata_d;
   logic [WORD_LENGTH-1:0]   stat_word;
   logic                     hit_gpio, hit_uart_tx, hit_uart_stat;

   if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   mmio_addr_decoder #(
      .WORD_LENGTH    (WORD_LENGTH),
      .GPIO_ADDR      (GPIO_ADDR),
      .UART_TX_ADDR   (UART_TX_ADDR),
      .UART_STAT_ADDR (UART_STAT_ADDR)
   ) u_decoder (
      .addr_i          (Address),
      .hit_gpio_o      (hit_gpio),
      .hit_uart_tx_o   (hit_uart_tx),
      .hit_uart_stat_o (hit_uart_stat)
   );

`ifdef MMIO_TIMEOUT_EN
   localparam int                TMO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0]  C_TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             ioerr_q, ioerr_d;

   assign IoError = ioerr_q;
`else
   assign IoError = 1'b0;
`endif

   always_comb begin
      stat_word                  = '0;
      stat_word[C_STAT_BUSY_BIT] = UartBusy;
      stat_word[C_STAT_ERR_BIT]  = IoError;
   end

   always_comb begin
      state_d     = state_q;
      gpio_d      = gpio_q;
      rdata_d     = rdata_q;
      txdata_d    = txdata_q;
      Stall       = 1'b0;
      UartTxStart = 1'b0;
`ifdef MMIO_TIMEOUT_EN
      tmo_cnt_d   = '0;
      ioerr_d     = ioerr_q;
`endif

      case (state_q)
         ST_IDLE: begin
            // A store wins over a simultaneous load; the load is dropped.
            if (MemWrite) begin
               if (hit_gpio) begin
                  gpio_d = WriteData;
               end else if (hit_uart_tx) begin
                  txdata_d = WriteData[7:0];
                  Stall    = 1'b1;
                  state_d  = UartBusy ? ST_UART_WAIT : ST_UART_START;
               end
            end else if (MemRead && (hit_gpio || hit_uart_tx || hit_uart_stat)) begin
               Stall   = 1'b1;
               state_d = ST_READ_RESP;
               if (hit_gpio) begin
                  rdata_d = gpio_q;
               end else if (hit_uart_stat) begin
                  rdata_d = stat_word;
               end else begin
                  rdata_d = WORD_LENGTH'(txdata_q);
               end
            end
         end

         ST_UART_WAIT: begin
            Stall = 1'b1;
            if (!UartBusy) begin
               state_d = ST_UART_START;
            end
`ifdef MMIO_TIMEOUT_EN
            // On expiry the held store is released so the CPU can move on.
            else if (tmo_cnt_q == C_TMO_LAST) begin
               ioerr_d = 1'b1;
               Stall   = 1'b0;
               state_d = ST_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
`endif
         end

         ST_UART_START: begin
            UartTxStart = 1'b1;
            state_d     = ST_IDLE;
         end

         ST_READ_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (reset) begin
         Stall       = 1'b0;
         UartTxStart = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         gpio_q   <= '0;
         rdata_q  <= '0;
         txdata_q <= '0;
`ifdef MMIO_TIMEOUT_EN
         tmo_cnt_q <= '0;
         ioerr_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         gpio_q   <= gpio_d;
         rdata_q  <= rdata_d;
         txdata_q <= txdata_d;
`ifdef MMIO_TIMEOUT_EN
         tmo_cnt_q <= tmo_cnt_d;
         ioerr_q   <= ioerr_d;
`endif
      end
   end

   assign GpioOut    = gpio_q;
   assign ReadData   = rdata_q;
   assign UartTxData = txdata_q;

endmodule : mmio_io_controller

`default_nettype wire
